overlay_pixel_gen: RTL and testbench

- Parametrised successor to the fixed-size game-over overlay generator.
- Maps VGA raster counters to a downscaled overlay image-memory address.
- Pipelines the memory's palette index through to a 12-bit RGB pixel.
- Drives BTN_COUNT clickable buttons, each with its own hover/press/click state machine, and emits one-cycle click pulses to the game controller.
- Sits between the VGA timing block and the screen multiplexer; the overlay memory is external and accessed through a read port.

---
 rtl/overlay_pkg.sv | 25 ++
 rtl/overlay_btn_fsm.sv | 54 +++++
 rtl/overlay_pixel_gen.sv | 129 ++++++++++++
 tb/tb_overlay_pixel_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : overlay_pkg
// Purpose  : Shared button-state encoding, default colours and palette indices
// Revision : 1.0 - initial parametrised release
// ============================================================================
package overlay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOVER = 2'd1,
    PRESS = 2'd2
  } btn_state_t;

  localparam logic [11:0] COL_BG    = 12'h000;
  localparam logic [11:0] COL_FG    = 12'hFFF;
  localparam logic [11:0] COL_TOUCH = 12'h32E;
  localparam logic [11:0] COL_CLICK = 12'h3E2;

  localparam int IDX_BG       = 0;
  localparam int IDX_FG       = 1;
  localparam int IDX_BTN_BASE = 2;

endpackage
`default_nettype wire

// File: rtl/overlay_btn_fsm.sv
`default_nettype none
// ============================================================================
// Module   : overlay_btn_fsm
// Purpose  : Hover/press/click tracker for one on-screen button
// Revision : 1.0 - initial parametrised release
// ============================================================================
module overlay_btn_fsm
  import overlay_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_on_btn,
  input  logic       i_press,
  input  logic       i_release,
  output btn_state_t o_state,
  output logic       o_click
);

  btn_state_t r_state;
  logic       r_click;

  // Leaving the button always disarms it, so a release off-button never clicks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_click <= 1'b0;
    end else begin
      r_click <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_on_btn) r_state <= HOVER;
        end
        HOVER: begin
          if (!i_on_btn)    r_state <= IDLE;
          else if (i_press) r_state <= PRESS;
        end
        PRESS: begin
          if (!i_on_btn) begin
            r_state <= IDLE;
          end else if (i_release) begin
            r_state <= HOVER;
            r_click <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_click = r_click;

endmodule
`default_nettype wire

// File: rtl/overlay_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : overlay_pixel_gen
// Purpose  : Downscaled overlay address generation, palette-to-RGB pipeline
//            and clickable button handling
// Revision : 1.0 - initial parametrised release
// ============================================================================
module overlay_pixel_gen #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          SCALE_SHIFT = 1,
  parameter int          ADDR_W      = 17,
  parameter int          IDX_W       = 2,
  parameter int          BTN_COUNT   = 2,
  parameter int          MEM_LAT     = 1,
  parameter logic [11:0] COL_BG      = overlay_pkg::COL_BG,
  parameter logic [11:0] COL_FG      = overlay_pkg::COL_FG,
  parameter logic [11:0] COL_TOUCH   = overlay_pkg::COL_TOUCH,
  parameter logic [11:0] COL_CLICK   = overlay_pkg::COL_CLICK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           i_h_cnt,
  input  logic [9:0]           i_v_cnt,
  input  logic                 i_video_valid,
  input  logic                 i_mouse_left,
  input  logic [BTN_COUNT-1:0] i_mouse_on_btn,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic [IDX_W-1:0]     i_mem_data,
  output logic [11:0]          o_pixel_out,
  output logic [BTN_COUNT-1:0] o_click_pulse
);

  import overlay_pkg::*;

  localparam logic [10:0]       c_H_LIM  = 11'(H_RES);
  localparam logic [10:0]       c_V_LIM  = 11'(V_RES);
  localparam logic [ADDR_W-1:0] c_LINE_W = ADDR_W'(H_RES >> SCALE_SHIFT);

  logic                 w_in_range;
  logic [ADDR_W-1:0]    w_col;
  logic [ADDR_W-1:0]    w_row;
  logic [ADDR_W-1:0]    w_row_base;
  logic                 w_press;
  logic                 w_release;
  logic [11:0]          w_colour;
  btn_state_t           w_btn_state [BTN_COUNT];
  logic [BTN_COUNT-1:0] w_click;

  logic [ADDR_W-1:0]    r_mem_addr;
  logic [MEM_LAT:0]     r_vld;
  logic [11:0]          r_pixel;
  logic                 r_left_prev;

  assign w_in_range = i_video_valid && ({1'b0, i_h_cnt} < c_H_LIM)
                                    && ({1'b0, i_v_cnt} < c_V_LIM);
  assign w_col = ADDR_W'(i_h_cnt >> SCALE_SHIFT);
  assign w_row = ADDR_W'(i_v_cnt >> SCALE_SHIFT);

  // Row base = line width * row, built from the set bits of the constant width.
  always_comb begin
    w_row_base = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (c_LINE_W[b]) w_row_base = w_row_base + (w_row << b);
    end
  end

  // r_vld[0] travels with the address; r_vld[MEM_LAT] lines up with i_mem_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
      r_vld      <= '0;
    end else begin
      r_mem_addr <= w_in_range ? (w_col + w_row_base) : '0;
      r_vld      <= {r_vld[MEM_LAT-1:0], w_in_range};
    end
  end

  // History starts high so a button held through reset is not seen as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_left_prev <= 1'b1;
    else        r_left_prev <= i_mouse_left;
  end

  assign w_press   =  i_mouse_left && !r_left_prev;
  assign w_release = !i_mouse_left &&  r_left_prev;

  for (genvar k = 0; k < BTN_COUNT; k++) begin : g_btn
    overlay_btn_fsm u_btn_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_on_btn  (i_mouse_on_btn[k]),
      .i_press   (w_press),
      .i_release (w_release),
      .o_state   (w_btn_state[k]),
      .o_click   (w_click[k])
    );
  end

  always_comb begin
    w_colour = COL_FG;
    if (i_mem_data == IDX_W'(IDX_BG)) begin
      w_colour = COL_BG;
    end else if (i_mem_data == IDX_W'(IDX_FG)) begin
      w_colour = COL_FG;
    end else begin
      for (int k = 0; k < BTN_COUNT; k++) begin
        if (i_mem_data == IDX_W'(IDX_BTN_BASE + k)) begin
          case (w_btn_state[k])
            HOVER:   w_colour = COL_TOUCH;
            PRESS:   w_colour = COL_CLICK;
            default: w_colour = COL_BG;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pixel <= '0;
    else        r_pixel <= r_vld[MEM_LAT] ? w_colour : 12'h000;
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_pixel_out   = r_pixel;
  assign o_click_pulse = w_click;

endmodule
`default_nettype wire

// File: tb/tb_overlay_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_overlay_pixel_gen
// Purpose  : Directed and randomized checks of overlay_pixel_gen (MEM_LAT=2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_overlay_pixel_gen;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int BTN_COUNT = 2;
  localparam int MEM_LAT   = 2;
  localparam int IMG_W     = 320;
  localparam int IMG_PIX   = 76800;
  localparam logic [11:0] BG    = 12'h000;
  localparam logic [11:0] FG    = 12'hFFF;
  localparam logic [11:0] TOUCH = 12'h32E;
  localparam logic [11:0] CLICK = 12'h3E2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt, v_cnt;
  logic        video_valid, mouse_left;
  logic [1:0]  mouse_on_btn;
  logic [16:0] mem_addr;
  logic [1:0]  mem_data;
  logic [11:0] pixel_out;
  logic [1:0]  click_pulse;

  always #5 clk = ~clk;

  overlay_pixel_gen #(.MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_h_cnt        (h_cnt),
    .i_v_cnt        (v_cnt),
    .i_video_valid  (video_valid),
    .i_mouse_left   (mouse_left),
    .i_mouse_on_btn (mouse_on_btn),
    .o_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .o_pixel_out    (pixel_out),
    .o_click_pulse  (click_pulse)
  );

  // External overlay memory with MEM_LAT-cycle read latency.
  logic [1:0] mem  [IMG_PIX];
  logic [1:0] rd_q [MEM_LAT];
  always @(posedge clk) begin
    rd_q[0] <= mem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign mem_data = rd_q[MEM_LAT-1];

  // Reference model: button states 0=idle 1=hover 2=press, plus a queue of
  // in-flight pixels (in_range, palette index) awaiting their output cycle.
  typedef struct { bit inr; int idx; } pend_t;
  pend_t       m_pend [$];
  int          m_state [BTN_COUNT];
  bit          m_left_prev;
  logic [11:0] exp_pix;
  logic [16:0] exp_addr;
  logic [1:0]  exp_click;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void model_reset();
    m_pend.delete();
    for (int i = 0; i < MEM_LAT + 1; i++) m_pend.push_back('{1'b0, 0});
    for (int k = 0; k < BTN_COUNT; k++) m_state[k] = 0;
    m_left_prev = 1'b1;
    exp_pix   = 12'h000;
    exp_addr  = 17'd0;
    exp_click = 2'b00;
  endfunction

  function automatic logic [11:0] ref_colour(int idx);
    if (idx == 0) return BG;
    if (idx == 1) return FG;
    if (idx >= 2 && idx < 2 + BTN_COUNT) begin
      case (m_state[idx-2])
        0:       return BG;
        1:       return TOUCH;
        default: return CLICK;
      endcase
    end
    return FG;
  endfunction

  // Advance one clock: inputs present now are sampled at the edge, the model
  // predicts post-edge outputs, and the caller compares 1 time unit later.
  task automatic step();
    bit        inr, left, press, rel;
    bit [1:0]  on;
    int        a;
    pend_t     e;
    inr  = video_valid && (h_cnt < H_RES) && (v_cnt < V_RES);
    a    = inr ? (int'(h_cnt) / 2 + IMG_W * (int'(v_cnt) / 2)) : 0;
    left = mouse_left;
    on   = mouse_on_btn;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_pend.push_back('{inr, int'(mem[a])});
      e        = m_pend.pop_front();
      exp_pix  = e.inr ? ref_colour(e.idx) : 12'h000;
      exp_addr = 17'(a);
      press    = left && !m_left_prev;
      rel      = !left && m_left_prev;
      for (int k = 0; k < BTN_COUNT; k++) begin
        exp_click[k] = 1'b0;
        if (!on[k])                          m_state[k] = 0;
        else if (m_state[k] == 0)            m_state[k] = 1;
        else if (m_state[k] == 1 && press)   m_state[k] = 2;
        else if (m_state[k] == 2 && rel) begin
          m_state[k]   = 1;
          exp_click[k] = 1'b1;
        end
      end
      m_left_prev = left;
    end
    #1;
  endtask

  task automatic set_cnt(int h, int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    video_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      h_cnt = 10'($urandom); v_cnt = 10'($urandom);
      video_valid = 1'($urandom); mouse_left = 1'($urandom);
      mouse_on_btn = 2'($urandom);
      step();
      n_checks++; if (pixel_out !== 12'h000) $display("FAIL reset_pixel: got %h want 000", pixel_out); else n_pass++;
      n_checks++; if (click_pulse !== 2'b00) $display("FAIL reset_click: got %b want 00", click_pulse); else n_pass++;
      n_checks++; if (mem_addr !== 17'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else n_pass++;
    end
    mouse_left = 1'b0; mouse_on_btn = 2'b00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_addr_map();
    set_cnt(10, 7); step();
    n_checks++; if (mem_addr !== 17'd965) $display("FAIL addr_10_7: got %0d want 965", mem_addr); else n_pass++;
    set_cnt(639, 479); step();
    n_checks++; if (mem_addr !== 17'd76799) $display("FAIL addr_639_479: got %0d want 76799", mem_addr); else n_pass++;
    set_cnt(640, 0); step();
    n_checks++; if (mem_addr !== 17'd0) $display("FAIL addr_640: got %0d want 0", mem_addr); else n_pass++;
    step(); step();
    n_checks++; if (pixel_out !== FG) $display("FAIL pix_639_479: got %h want fff", pixel_out); else n_pass++;
    step();
    n_checks++; if (pixel_out !== 12'h000) $display("FAIL pix_640_blank: got %h want 000", pixel_out); else n_pass++;
  endtask

  task automatic test_latency();
    video_valid = 1'b0;
    repeat (5) step();
    set_cnt(10, 7);
    for (int s = 1; s <= 4; s++) begin
      step();
      if (s < 4) begin
        n_checks++; if (pixel_out !== 12'h000) $display("FAIL latency_early_%0d: got %h want 000", s, pixel_out); else n_pass++;
      end else begin
        n_checks++; if (pixel_out !== FG) $display("FAIL latency_idx1: got %h want fff", pixel_out); else n_pass++;
      end
    end
    set_cnt(22, 7);
    step(); step(); step();
    n_checks++; if (pixel_out !== FG) $display("FAIL latency_hold: got %h want fff", pixel_out); else n_pass++;
    step();
    n_checks++; if (pixel_out !== BG) $display("FAIL idx3_idle: got %h want 000", pixel_out); else n_pass++;
  endtask

  task automatic test_click();
    set_cnt(20, 7);
    mouse_on_btn = 2'b01;
    repeat (4) step();
    n_checks++; if (pixel_out !== TOUCH) $display("FAIL click_hover: got %h want 32e", pixel_out); else n_pass++;
    mouse_left = 1'b1;
    step(); step();
    n_checks++; if (pixel_out !== CLICK) $display("FAIL click_press: got %h want 3e2", pixel_out); else n_pass++;
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL click_early: got %b want 00", click_pulse); else n_pass++;
    mouse_left = 1'b0;
    step();
    n_checks++; if (click_pulse !== 2'b01) $display("FAIL click_pulse: got %b want 01", click_pulse); else n_pass++;
    step();
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL click_one_cycle: got %b want 00", click_pulse); else n_pass++;
    n_checks++; if (pixel_out !== TOUCH) $display("FAIL click_back_hover: got %h want 32e", pixel_out); else n_pass++;
  endtask

  task automatic test_abort();
    mouse_left = 1'b1;
    step(); step();
    n_checks++; if (pixel_out !== CLICK) $display("FAIL abort_press: got %h want 3e2", pixel_out); else n_pass++;
    mouse_on_btn = 2'b00;
    step();
    mouse_left = 1'b0;
    step();
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL abort_no_pulse: got %b want 00", click_pulse); else n_pass++;
    n_checks++; if (pixel_out !== BG) $display("FAIL abort_idle: got %h want 000", pixel_out); else n_pass++;
    step();
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL abort_late: got %b want 00", click_pulse); else n_pass++;
  endtask

  task automatic test_drag_reset();
    set_cnt(22, 7);
    mouse_left = 1'b1;
    step(); step();
    mouse_on_btn = 2'b10;
    repeat (4) step();
    n_checks++; if (pixel_out !== TOUCH) $display("FAIL drag_in_hover: got %h want 32e", pixel_out); else n_pass++;
    mouse_left = 1'b0;
    step();
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL drag_release: got %b want 00", click_pulse); else n_pass++;
    mouse_on_btn = 2'b00;
    step(); step();
    mouse_on_btn = 2'b10; mouse_left = 1'b1;
    step(); step();
    n_checks++; if (pixel_out !== TOUCH) $display("FAIL enter_and_press: got %h want 32e", pixel_out); else n_pass++;
    mouse_left = 1'b0; mouse_on_btn = 2'b00;
    step();

    set_cnt(20, 7);
    mouse_on_btn = 2'b01;
    step();
    mouse_left = 1'b1;
    repeat (4) step();
    n_checks++; if (pixel_out !== CLICK) $display("FAIL pre_reset_press: got %h want 3e2", pixel_out); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (pixel_out !== 12'h000) $display("FAIL async_reset_pixel: got %h want 000", pixel_out); else n_pass++;
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL async_reset_click: got %b want 00", click_pulse); else n_pass++;
    n_checks++; if (mem_addr !== 17'd0) $display("FAIL async_reset_addr: got %0d want 0", mem_addr); else n_pass++;
    step(); step();
    rst_n = 1'b1;
    repeat (6) step();
    n_checks++; if (pixel_out !== TOUCH) $display("FAIL held_after_reset: got %h want 32e", pixel_out); else n_pass++;
    mouse_left = 1'b0;
    step();
    n_checks++; if (click_pulse !== 2'b00) $display("FAIL held_release: got %b want 00", click_pulse); else n_pass++;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      h_cnt = 10'($urandom_range(0, 700));
      v_cnt = 10'($urandom_range(0, 520));
      video_valid = ($urandom % 8) != 0;
      if (($urandom % 4) == 0) mouse_left = ~mouse_left;
      if (($urandom % 3) == 0) begin
        r = int'($urandom % 8);
        mouse_on_btn = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      end
      step();
      n_checks++; if (pixel_out !== exp_pix) $display("FAIL rand_pixel[%0d]: got %h want %h", i, pixel_out, exp_pix); else n_pass++;
      n_checks++; if (mem_addr !== exp_addr) $display("FAIL rand_addr[%0d]: got %0d want %0d", i, mem_addr, exp_addr); else n_pass++;
      n_checks++; if (click_pulse !== exp_click) $display("FAIL rand_click[%0d]: got %b want %b", i, click_pulse, exp_click); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < IMG_PIX; i++) mem[i] = 2'($urandom);
    mem[965]   = 2'd1;
    mem[76799] = 2'd1;
    mem[970]   = 2'd2;
    mem[971]   = 2'd3;
    rst_n = 1'b0;
    h_cnt = '0; v_cnt = '0; video_valid = 1'b0;
    mouse_left = 1'b0; mouse_on_btn = 2'b00;
    model_reset();
    test_reset();
    test_addr_map();
    test_latency();
    test_click();
    test_abort();
    test_drag_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
